// File: rtl/canny_pkg.sv
// Shared Canny-pipeline types: window-shift command codes and scan FSM states.
// The main controller drives its buffer codes with the same shift_mode_t.
package canny_pkg;

  typedef enum logic [1:0] {
    SHIFT_HOLD  = 2'b00,
    SHIFT_RIGHT = 2'b01,
    SHIFT_LEFT  = 2'b10,
    SHIFT_DOWN  = 2'b11
  } shift_mode_t;

  typedef enum logic {
    SCAN_IDLE = 1'b0,
    SCAN_RUN  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/scan_position_generator_if.sv
// Controller <-> scan position generator bundle: shift commands in, window
// coordinates, row/image-end flags and linear read address out.
interface scan_position_generator_if
  import canny_pkg::*;
#(
  parameter int X_W    = 8,
  parameter int Y_W    = 8,
  parameter int ADDR_W = 16
);
  logic              start;
  logic              advance;
  shift_mode_t       shift_mode;
  logic [X_W-1:0]    readx;
  logic [Y_W-1:0]    ready;
  logic              readx_up_max;
  logic              readx_down_min;
  logic              ready_done;
  logic              scan_dir;
  logic              scanning;
  logic              scan_complete;
  logic [ADDR_W-1:0] read_addr;

  modport master (
    output start, advance, shift_mode,
    input  readx, ready, readx_up_max, readx_down_min, ready_done,
           scan_dir, scanning, scan_complete, read_addr
  );

  modport slave (
    input  start, advance, shift_mode,
    output readx, ready, readx_up_max, readx_down_min, ready_done,
           scan_dir, scanning, scan_complete, read_addr
  );
endinterface

// File: rtl/scan_axis_counter.sv
// Loadable up/down counter saturating at 0 and MAX; reports its next value
// and whether the pending update actually moves it.
module scan_axis_counter #(
  parameter int W   = 8,
  parameter int MAX = 0
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic [W-1:0] nxt,
  output logic         moved
);
  localparam logic [W-1:0] MAX_V = W'(MAX);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    nxt   = cnt;
    moved = 1'b0;
    if (clr) begin
      nxt = '0;
    end else if (inc && cnt != MAX_V) begin
      nxt   = cnt + W'(1);
      moved = 1'b1;
    end else if (dec && cnt != '0) begin
      nxt   = cnt - W'(1);
      moved = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample together.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) cnt <= '0;
    else        cnt <= nxt;
  end
endmodule

// File: rtl/scan_position_generator.sv
// Serpentine scan position of the WINxWIN window over the image.
// Optional linear read address tracking under `define SCAN_LINEAR_ADDR_EN.
module scan_position_generator
  import canny_pkg::*;
#(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int WIN    = 9,
  parameter int X_W    = $clog2(IMG_W),
  parameter int Y_W    = $clog2(IMG_H),
  parameter int ADDR_W = $clog2(IMG_W * IMG_H)
) (
  input logic                      clk,
  input logic                      n_rst,
  scan_position_generator_if.slave bus
);
  localparam int             XMAX   = IMG_W - WIN;
  localparam int             YMAX   = IMG_H - WIN;
  localparam logic [X_W-1:0] XMAX_V = X_W'(XMAX);
  localparam logic [Y_W-1:0] YMAX_V = Y_W'(YMAX);

  scan_state_t    state, state_nxt;
  logic           do_shift;
  logic [X_W-1:0] x_q, x_nxt;
  logic [Y_W-1:0] y_q, y_nxt;
  logic           x_mv, y_mv;
  logic           dir_q, dir_nxt;
  logic           complete_q, complete_nxt;

  // start outranks advance; shifts only count while scanning
  assign do_shift = (state == SCAN_RUN) && bus.advance && !bus.start;

  scan_axis_counter #(.W(X_W), .MAX(XMAX)) u_x (
    .clk   (clk),
    .n_rst (n_rst),
    .clr   (bus.start),
    .inc   (do_shift && bus.shift_mode == SHIFT_RIGHT),
    .dec   (do_shift && bus.shift_mode == SHIFT_LEFT),
    .cnt   (x_q),
    .nxt   (x_nxt),
    .moved (x_mv)
  );

  scan_axis_counter #(.W(Y_W), .MAX(YMAX)) u_y (
    .clk   (clk),
    .n_rst (n_rst),
    .clr   (bus.start),
    .inc   (do_shift && bus.shift_mode == SHIFT_DOWN),
    .dec   (1'b0),
    .cnt   (y_q),
    .nxt   (y_nxt),
    .moved (y_mv)
  );

  // Completion only on a real move onto the row-end column of the last row,
  // so saturated shifts afterwards cannot re-fire it.
  always_comb begin
    dir_nxt      = bus.start ? 1'b0 : (dir_q ^ y_mv);
    complete_nxt = (x_mv || y_mv) && (y_nxt == YMAX_V) &&
                   (x_nxt == (dir_nxt ? '0 : XMAX_V));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SCAN_IDLE: if (bus.start) state_nxt = SCAN_RUN;
      SCAN_RUN:  if (!bus.start && complete_q) state_nxt = SCAN_IDLE;
      default:   state_nxt = SCAN_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= SCAN_IDLE;
      dir_q      <= 1'b0;
      complete_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      dir_q      <= dir_nxt;
      complete_q <= complete_nxt;
    end
  end

`ifdef SCAN_LINEAR_ADDR_EN
  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(IMG_W);
  logic [ADDR_W-1:0] addr_q;

  // Incremental tracking: at most one axis moves per cycle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                                        addr_q <= '0;
    else if (bus.start)                                addr_q <= '0;
    else if (y_mv)                                     addr_q <= addr_q + ROW_STRIDE;
    else if (x_mv && bus.shift_mode == SHIFT_RIGHT)    addr_q <= addr_q + ADDR_W'(1);
    else if (x_mv)                                     addr_q <= addr_q - ADDR_W'(1);
  end

  assign bus.read_addr = addr_q;
`else
  assign bus.read_addr = {ADDR_W{1'b0}};
`endif

  assign bus.readx          = x_q;
  assign bus.ready          = y_q;
  assign bus.readx_up_max   = (x_q == XMAX_V);
  assign bus.readx_down_min = (x_q == '0);
  assign bus.ready_done     = (y_q == YMAX_V);
  assign bus.scan_dir       = dir_q;
  assign bus.scanning       = (state == SCAN_RUN);
  assign bus.scan_complete  = complete_q;
endmodule

// File: tb/tb_scan_position_generator.sv
// Self-checking bench for scan_position_generator on a 16x12 image (XMAX=7, YMAX=3),
// directed steps followed by randomized commands against a coordinate-level model.
module tb_scan_position_generator;
  import canny_pkg::*;

  localparam int IMG_W = 16;
  localparam int IMG_H = 12;
  localparam int WIN   = 9;
  localparam int XMAX  = IMG_W - WIN;
  localparam int YMAX  = IMG_H - WIN;

  logic clk;
  logic n_rst;
  int   checks;
  int   failures;

  // reference model: window origin, direction, run flag, completion pulse
  int mx, my, mdir, mrun, mcomp;
  int pulses;

  scan_position_generator_if #(.X_W(4), .Y_W(4), .ADDR_W(8)) bus ();

  scan_position_generator #(.IMG_W(IMG_W), .IMG_H(IMG_H), .WIN(WIN)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model_addr();
`ifdef SCAN_LINEAR_ADDR_EN
    return my * IMG_W + mx;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    mx = 0; my = 0; mdir = 0; mrun = 0; mcomp = 0;
  endtask

  // One clock edge of the specified behaviour, applied to the model.
  task automatic model_edge(input bit st, input bit adv, input int mode);
    bit moved;
    int was_comp;
    moved    = 0;
    was_comp = mcomp;
    if (st) begin
      mx = 0; my = 0; mdir = 0; mrun = 1; mcomp = 0;
    end else if (mrun != 0) begin
      if (adv) begin
        if (mode == 1 && mx < XMAX) begin mx = mx + 1; moved = 1; end
        if (mode == 2 && mx > 0)    begin mx = mx - 1; moved = 1; end
        if (mode == 3 && my < YMAX) begin my = my + 1; mdir = 1 - mdir; moved = 1; end
      end
      mcomp = (moved && my == YMAX && mx == (mdir != 0 ? 0 : XMAX)) ? 1 : 0;
      if (was_comp != 0) mrun = 0;
    end else begin
      mcomp = 0;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".readx"},     32'(bus.readx),          32'(mx));
    check({tag, ".ready"},     32'(bus.ready),          32'(my));
    check({tag, ".up_max"},    32'(bus.readx_up_max),   32'(mx == XMAX));
    check({tag, ".down_min"},  32'(bus.readx_down_min), 32'(mx == 0));
    check({tag, ".done"},      32'(bus.ready_done),     32'(my == YMAX));
    check({tag, ".scan_dir"},  32'(bus.scan_dir),       32'(mdir));
    check({tag, ".scanning"},  32'(bus.scanning),       32'(mrun));
    check({tag, ".complete"},  32'(bus.scan_complete),  32'(mcomp));
    check({tag, ".read_addr"}, 32'(bus.read_addr),      32'(model_addr()));
  endtask

  task automatic step(input string tag, input bit st, input bit adv, input int mode);
    @(negedge clk);
    bus.start      = st;
    bus.advance    = adv;
    bus.shift_mode = shift_mode_t'(mode[1:0]);
    @(posedge clk);
    model_edge(st, adv, mode);
    #1;
    if (bus.scan_complete === 1'b1) pulses++;
    check_model(tag);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    pulses   = 0;
    bus.start      = 1'b0;
    bus.advance    = 1'b0;
    bus.shift_mode = SHIFT_HOLD;
    n_rst = 1'b0;
    model_reset();
    #12;
    check_model("reset");
    @(negedge clk);
    n_rst = 1'b1;

    // advance is ignored while idle
    for (int i = 0; i < 5; i++) step("idle_adv", 1'b0, 1'b1, 1);
    check("idle_readx", 32'(bus.readx), 32'd0);

    // first row rightward, then saturation
    step("start", 1'b1, 1'b0, 0);
    for (int i = 0; i < 7; i++) step("right", 1'b0, 1'b1, 1);
    check("row_end_x", 32'(bus.readx), 32'd7);
    check("row_end_flag", 32'(bus.readx_up_max), 32'd1);
    step("right_sat", 1'b0, 1'b1, 1);
    check("sat_x", 32'(bus.readx), 32'd7);
    step("hold", 1'b0, 1'b1, 0);
    step("down", 1'b0, 1'b1, 3);
    check("down_y", 32'(bus.ready), 32'd1);
    check("down_dir", 32'(bus.scan_dir), 32'd1);
    for (int i = 0; i < 7; i++) step("left", 1'b0, 1'b1, 2);
    check("row1_min", 32'(bus.readx_down_min), 32'd1);

    // finish the serpentine: rows 2 and 3
    step("down2", 1'b0, 1'b1, 3);
    for (int i = 0; i < 7; i++) step("right2", 1'b0, 1'b1, 1);
    step("down3", 1'b0, 1'b1, 3);
    check("last_row_done", 32'(bus.ready_done), 32'd1);
    for (int i = 0; i < 7; i++) step("left3", 1'b0, 1'b1, 2);
    check("complete_pulse", 32'(bus.scan_complete), 32'd1);
    step("extra_left", 1'b0, 1'b1, 2);
    check("scanning_drop", 32'(bus.scanning), 32'd0);
    step("extra_left2", 1'b0, 1'b1, 2);
    check("one_pulse", 32'(pulses), 32'd1);

    // start beats advance at readx=5, ready=2
    step("start2", 1'b1, 1'b0, 0);
    step("d_a", 1'b0, 1'b1, 3);
    step("d_b", 1'b0, 1'b1, 3);
    for (int i = 0; i < 5; i++) step("r5", 1'b0, 1'b1, 1);
    check("pre_restart_x", 32'(bus.readx), 32'd5);
    step("restart", 1'b1, 1'b1, 1);
    check("restart_x", 32'(bus.readx), 32'd0);
    check("restart_dir", 32'(bus.scan_dir), 32'd0);

    // asynchronous reset mid-row
    for (int i = 0; i < 4; i++) step("r4", 1'b0, 1'b1, 1);
    @(negedge clk);
    bus.advance = 1'b0;
    #2;
    n_rst = 1'b0;
    #1;
    model_reset();
    check_model("async_rst");
    @(negedge clk);
    n_rst = 1'b1;

    // randomized command stream
    for (int i = 0; i < 600; i++) begin
      bit st;
      bit adv;
      int mode;
      st   = ($urandom_range(0, 39) == 0);
      adv  = ($urandom_range(0, 3) != 0);
      mode = int'($urandom_range(0, 3));
      step("rand", st, adv, mode);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
